// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_pkg
//  Description : Shared types and register map for the MMIO UART transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] c_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] c_OFF_STATUS  = 2'd1;
    localparam logic [1:0] c_OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] c_OFF_CTRL    = 2'd3;

    localparam int c_ST_BUSY  = 0;
    localparam int c_ST_FULL  = 1;
    localparam int c_ST_EMPTY = 2;
    localparam int c_ST_OVF   = 3;

    // A divisor of zero would stall the serialiser; treat it as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_fifo
//  Description : Synchronous FIFO; a pop frees a slot for a same-cycle push.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]    w_off;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_dout;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_busy;
    logic          w_bit_end;
    logic [15:0]   w_div_m1;
    logic          w_unused;

    logic [15:0]   r_baud;
    logic          r_ien;
    logic          r_ovf;
    uart_state_t   r_state;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    assign sel       = (address[31:4] == BASE_ADDR[31:4]);
    assign w_off     = address[3:2];
    assign w_wr      = sel & we;
    assign w_push    = w_wr & (w_off == c_OFF_TXDATA);
    assign w_busy    = (r_state != S_IDLE);
    assign w_bit_end = (r_cnt == 16'd0);
    assign w_div_m1  = eff_div(r_baud) - 16'd1;
    // The FIFO is drained from IDLE, and at the end of a stop bit so frames abut.
    assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    assign tx        = r_tx;
    assign irq       = r_ien & w_empty & ~w_busy;
    assign w_unused  = &{1'b0, address[1:0], wdata[31:16]};

    mmio_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (wdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud <= DEFAULT_DIV;
            r_ien  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr && w_off == c_OFF_BAUDDIV) r_baud <= wdata[15:0];
            if (w_wr && w_off == c_OFF_CTRL)    r_ien  <= wdata[0];
            if (w_wr && w_off == c_OFF_STATUS && wdata[c_ST_OVF])
                r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_START;
                        r_shift <= w_dout;
                        r_tx    <= 1'b0;
                        r_cnt   <= w_div_m1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= 3'd0;
                        r_cnt   <= w_div_m1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= w_div_m1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= w_div_m1;
                        if (!w_empty) begin
                            r_state <= S_START;
                            r_shift <= w_dout;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (w_off)
                c_OFF_STATUS: begin
                    rdata[c_ST_BUSY]  = w_busy;
                    rdata[c_ST_FULL]  = w_full;
                    rdata[c_ST_EMPTY] = w_empty;
                    rdata[c_ST_OVF]   = r_ovf;
                    rdata[7:4]        = 4'(w_count);
                end
                c_OFF_BAUDDIV: rdata[15:0] = r_baud;
                c_OFF_CTRL:    rdata[0]    = r_ien;
                default:       rdata       = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx against a line-waveform model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;
    logic        irq;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .sel     (sel),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pending bytes, plus the per-clock line samples of the frame in flight.
    logic [7:0] m_q[$];
    bit         m_line[$];
    bit         m_busy;
    bit         m_tx;
    bit         m_ovf;
    bit         m_ien;
    int         m_div;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_line.delete();
        m_busy = 0;
        m_tx   = 1;
        m_ovf  = 0;
        m_ien  = 0;
        m_div  = 434;
    endtask

    task automatic model_edge(input bit wr, input logic [1:0] off, input logic [31:0] d);
        logic [7:0] b;
        int         eff;
        if (m_line.size() == 0 && m_q.size() != 0) begin
            b   = m_q.pop_front();
            eff = (m_div == 0) ? 1 : m_div;
            for (int k = 0; k < 10; k++)
                repeat (eff) m_line.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
        end
        m_busy = (m_line.size() != 0);
        m_tx   = m_busy ? m_line.pop_front() : 1'b1;
        if (wr) begin
            case (off)
                2'd0: if (m_q.size() < DEPTH) m_q.push_back(d[7:0]); else m_ovf = 1;
                2'd1: if (d[3]) m_ovf = 0;
                2'd2: m_div = int'(d[15:0]);
                default: m_ien = d[0];
            endcase
        end
    endtask

    task automatic cyc(input bit wr, input logic [31:0] addr, input logic [31:0] d);
        address = addr;
        wdata   = d;
        we      = wr;
        @(posedge clk);
        model_edge(wr && (addr[31:4] == BASE[31:4]), addr[3:2], d);
        #1;
        we = 0;
        chk("tx", {31'b0, tx}, {31'b0, m_tx});
        chk("irq", {31'b0, irq}, {31'b0, m_ien & (m_q.size() == 0) & ~m_busy});
    endtask

    task automatic idle();
        cyc(0, BASE + 32'h4, 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] e);
        address = BASE + off;
        we      = 0;
        #1;
        chk(tag, rdata, e);
        chk({tag, "_sel"}, {31'b0, sel}, 32'd1);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] e;
        e      = 32'd0;
        e[0]   = m_busy;
        e[1]   = (m_q.size() == DEPTH);
        e[2]   = (m_q.size() == 0);
        e[3]   = m_ovf;
        e[7:4] = 4'(m_q.size());
        rd_check(tag, 32'h4, e);
    endtask

    task automatic drain(input int limit, input bit with_status);
        int n = 0;
        while ((m_line.size() != 0 || m_q.size() != 0) && n < limit) begin
            idle();
            if (with_status) check_status("status_drain");
            n++;
        end
        chk("drain_bound", {31'b0, n < limit}, 32'd1);
        idle();
        check_status("status_after_drain");
    endtask

    initial begin
        logic [7:0] b;
        int         n;
        rst     = 1;
        we      = 0;
        address = 32'd0;
        wdata   = 32'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("tx_in_reset", {31'b0, tx}, 32'd1);
        @(negedge clk);
        rst = 0;
        rd_check("status_reset", 32'h4, 32'h04);
        rd_check("bauddiv_reset", 32'h8, 32'd434);
        rd_check("ctrl_reset", 32'hC, 32'd0);
        rd_check("txdata_read", 32'h0, 32'd0);
        chk("irq_reset", {31'b0, irq}, 32'd0);

        // Single 0xA5 frame at four clocks per bit
        cyc(1, BASE + 32'h8, 32'd4);
        rd_check("bauddiv_4", 32'h8, 32'd4);
        cyc(1, BASE + 32'h0, 32'hA5);
        idle();
        check_status("status_a5_busy");
        drain(200, 0);

        // Back-to-back bytes with interrupt enabled
        cyc(1, BASE + 32'hC, 32'd1);
        rd_check("ctrl_ien", 32'hC, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1, BASE, $urandom & 32'hFF);
        check_status("status_b2b");
        drain(500, 1);

        // Decode: window miss and ignored low address bits
        cyc(1, BASE + 32'h10, 32'h55);
        address = BASE + 32'h10;
        #1;
        chk("sel_miss", {31'b0, sel}, 32'd0);
        chk("rdata_miss", rdata, 32'd0);
        repeat (20) idle();
        check_status("status_after_miss");
        cyc(1, BASE + 32'hA, 32'd3);
        rd_check("bauddiv_lowbits", 32'hB, 32'd3);

        // Random frames, divisors including zero, random gaps
        for (int r = 0; r < 6; r++) begin
            cyc(1, BASE + 32'h8, $urandom_range(0, 4));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                cyc(1, BASE, $urandom & 32'hFF);
                repeat ($urandom_range(0, 2)) idle();
            end
            check_status("status_rand");
            drain(2000, 0);
        end

        // Overflow: one popped, eight queued, tenth dropped
        cyc(1, BASE + 32'h8, 32'd100);
        b = 8'($urandom) & 8'hF7;
        cyc(1, BASE, {24'd0, b});
        for (int i = 0; i < 9; i++) cyc(1, BASE, $urandom & 32'hFF);
        check_status("status_ovf");
        cyc(1, BASE + 32'h4, 32'h8);
        check_status("status_ovf_clr");

        // Reset in the middle of data bit 3 (bit value forced to 0 above)
        n = 0;
        while (m_line.size() != 549 && n < 2000) begin
            idle();
            n++;
        end
        chk("reach_bit3", {31'b0, n < 2000}, 32'd1);
        chk("tx_bit3_low", {31'b0, tx}, 32'd0);
        #2;
        rst = 1;
        #1;
        model_reset();
        chk("tx_async_reset", {31'b0, tx}, 32'd1);
        check_status("status_async_reset");
        @(negedge clk);
        rst = 0;
        rd_check("bauddiv_after_reset", 32'h8, 32'd434);
        repeat (60) idle();
        check_status("status_no_frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
